pipe_stage_hs: RTL and testbench

Parametrised pipeline stage register for the vector pipeline; successor to the fixed-field stage registers between Decode, Execute, Memory and Writeback.
- Carries a generic control field (cleared on bubble or flush) and a data field (held), with valid/ready handshake, hazard stall and flush.
- Two-entry skid buffer keeps full throughput with a registered in_ready.
- Instantiated once per stage boundary, with fields packed by the parent.

---
 rtl/pipe_stage_hs.sv | 167 ++++++++++++++++
 tb/tb_pipe_stage_hs.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// hazard stall and flush.
//
// Optional build macro: PIPE_STATS_EN builds saturating stall/bubble
// statistics counters; when undefined, stall_cnt and bubble_cnt read 0.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   in_valid/in_ready upstream handshake (in_ready registered, = !skid_full)
//   in_ctrl/in_data   upstream control / data payload
//   stall, flush      hazard unit controls (flush has priority)
//   out_valid/out_ready downstream handshake
//   out_ctrl/out_data output payload (ctrl is 0 whenever out_valid is 0)
//   stall_cnt         cycles with stall & out_valid
//   bubble_cnt        cycles with !out_valid
module pipe_stage_hs #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 112,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [CTRL_W-1:0]   r_main_ctrl, w_main_ctrl_nxt;
  logic [DATA_W-1:0]   r_main_data, w_main_data_nxt;
  logic [CTRL_W-1:0]   r_skid_ctrl, w_skid_ctrl_nxt;
  logic [DATA_W-1:0]   r_skid_data, w_skid_data_nxt;
  logic                r_out_valid, w_out_valid_nxt;
  logic                r_in_ready,  w_in_ready_nxt;

  logic                w_in_fire;
  logic                w_out_fire;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready & ~stall;

  // State and payload registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;   // skid is empty out of reset
    end else begin
      r_state     <= w_state_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_main_data <= w_main_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
    end
  end

  // Next state and payload steering
  always_comb begin
    w_state_nxt     = r_state;
    w_main_ctrl_nxt = r_main_ctrl;
    w_main_data_nxt = r_main_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    w_skid_data_nxt = r_skid_data;

    if (flush) begin
      // Kill every held entry and any entry arriving this cycle; data is kept.
      w_state_nxt     = ST_EMPTY;
      w_main_ctrl_nxt = '0;
      w_skid_ctrl_nxt = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt     = ST_ONE;
            w_main_ctrl_nxt = in_ctrl;
            w_main_data_nxt = in_data;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_ctrl_nxt = in_ctrl;
            w_main_data_nxt = in_data;
          end else if (w_in_fire) begin
            // Output is blocked (backpressure or stall): park new entry in skid.
            w_state_nxt     = ST_FULL;
            w_skid_ctrl_nxt = in_ctrl;
            w_skid_data_nxt = in_data;
          end else if (w_out_fire) begin
            // Bubble: control cleared so out_ctrl reads 0 while invalid.
            w_state_nxt     = ST_EMPTY;
            w_main_ctrl_nxt = '0;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_state_nxt     = ST_ONE;
            w_main_ctrl_nxt = r_skid_ctrl;
            w_main_data_nxt = r_skid_data;
            w_skid_ctrl_nxt = '0;
          end
        end
        default: begin
          w_state_nxt     = ST_EMPTY;
          w_main_ctrl_nxt = '0;
          w_skid_ctrl_nxt = '0;
        end
      endcase
    end

    // Handshake outputs are registered copies of the next-state decode.
    w_out_valid_nxt = (w_state_nxt != ST_EMPTY);
    w_in_ready_nxt  = (w_state_nxt != ST_FULL);
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Saturating statistics counters, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (stall && r_out_valid && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (!r_out_valid && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Self-checking bench for pipe_stage_hs: directed stimulus pushes expected
// entries into a queue; a negedge monitor pops and compares on every out_fire.
module tb_pipe_stage_hs;

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned DATA_W = 112;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_total = 0;
  int n_bad   = 0;

  logic [CTRL_W+DATA_W-1:0] exp_q[$];

  pipe_stage_hs #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted output against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready && !stall && !flush) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_out: got ctrl %0h data %0h expected no entry", out_ctrl, out_data);
        end else begin
          logic [CTRL_W+DATA_W-1:0] e;
          e = exp_q.pop_front();
          chk("out_ctrl", 128'(out_ctrl), 128'(e[CTRL_W+DATA_W-1:DATA_W]));
          chk("out_data", 128'(out_data), 128'(e[DATA_W-1:0]));
        end
      end
      if (!out_valid)
        chk("bubble_ctrl_zero", 128'(out_ctrl), 128'(0));
    end
  end

  // One clock of stimulus; returns 1 time unit after the active edge.
  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic ordy, input logic stl, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    stall     = stl;
    flush     = fl;
    if (fl)
      exp_q.delete();
    else if (v && in_ready)
      exp_q.push_back({c, d});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    stall     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  logic [CNT_W-1:0] exp_stall3;
  logic [CNT_W-1:0] exp_bub_sat;

  initial begin
`ifdef PIPE_STATS_EN
    exp_stall3  = CNT_W'(3);
    exp_bub_sat = CNT_W'(15);
`else
    exp_stall3  = '0;
    exp_bub_sat = '0;
`endif
    do_reset();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));

    // Single entry, one-cycle latency, then bubble with data held
    drive(1'b1, 16'h00A5, 112'd1, 1'b1, 1'b0, 1'b0);
    chk("single_valid", 128'(out_valid), 128'(1));
    chk("single_ctrl", 128'(out_ctrl), 128'(16'h00A5));
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("single_bub_valid", 128'(out_valid), 128'(0));
    chk("single_bub_ctrl", 128'(out_ctrl), 128'(0));
    chk("single_bub_data", 128'(out_data), 128'(1));

    // Full-throughput stream of 8
    for (int i = 1; i <= 8; i++) begin
      chk("stream_in_ready", 128'(in_ready), 128'(1));
      drive(1'b1, CTRL_W'(i), DATA_W'(i), 1'b1, 1'b0, 1'b0);
      chk("stream_out_valid", 128'(out_valid), 128'(1));
    end
    idle(1);
    chk("stream_drained", 128'(out_valid), 128'(0));

    // Backpressure fills skid, then drains in order
    drive(1'b1, 16'd1, 112'h101, 1'b0, 1'b0, 1'b0);
    chk("bp_ready_one", 128'(in_ready), 128'(1));
    drive(1'b1, 16'd2, 112'h102, 1'b0, 1'b0, 1'b0);
    chk("bp_ready_full", 128'(in_ready), 128'(0));
    chk("bp_head_ctrl", 128'(out_ctrl), 128'(1));
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("bp_ready_after", 128'(in_ready), 128'(1));
    chk("bp_second_ctrl", 128'(out_ctrl), 128'(2));
    idle(2);

    // Flush from FULL with a competing input
    drive(1'b1, 16'd4, 112'h40, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'd5, 112'h50, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'd3, 112'h30, 1'b0, 1'b0, 1'b1);
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_ctrl", 128'(out_ctrl), 128'(0));
    chk("flush_in_ready", 128'(in_ready), 128'(1));
    chk("flush_data_held", 128'(out_data), 128'(112'h40));
    idle(3);

    // Flush from ONE drops the entry being accepted the same cycle
    drive(1'b1, 16'd6, 112'h60, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'd7, 112'h70, 1'b1, 1'b0, 1'b1);
    chk("flush1_valid", 128'(out_valid), 128'(0));
    idle(3);

    // Stall in ONE for 3 cycles; skid still accepts on the third
    do_reset();
    drive(1'b1, 16'h0011, 112'h11, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    chk("stall_hold1", 128'(out_ctrl), 128'(16'h0011));
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    chk("stall_hold2", 128'(out_ctrl), 128'(16'h0011));
    drive(1'b1, 16'h0012, 112'h12, 1'b1, 1'b1, 1'b0);
    chk("stall_hold3", 128'(out_ctrl), 128'(16'h0011));
    chk("stall_valid", 128'(out_valid), 128'(1));
    chk("stall_skid_full", 128'(in_ready), 128'(0));
    chk("stall_cnt", 128'(stall_cnt), 128'(exp_stall3));
    idle(3);

    // Bubble counter saturation
    do_reset();
    idle(20);
    chk("bubble_sat", 128'(bubble_cnt), 128'(exp_bub_sat));

    // Asynchronous reset mid-stream
    drive(1'b1, 16'h0021, 112'h21, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h0022, 112'h22, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    exp_q.delete();
    chk("areset_valid", 128'(out_valid), 128'(0));
    chk("areset_ctrl", 128'(out_ctrl), 128'(0));
    chk("areset_data", 128'(out_data), 128'(0));
    chk("areset_in_ready", 128'(in_ready), 128'(1));
    chk("areset_bubble_cnt", 128'(bubble_cnt), 128'(0));
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
